// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types, arbiter state encoding and the ibus-to-dbus request adapter.
package mem_bus_arbiter_pkg;

   localparam int unsigned AddrW = 32;
   localparam int unsigned DataW = 32;

   // Fetches are always full-word reads.
   localparam logic [2:0] SizeWord = 3'd2;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic             valid;
      logic [AddrW-1:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic             addr_ok;
      logic             data_ok;
      logic [DataW-1:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic             valid;
      logic [AddrW-1:0] addr;
      logic [2:0]       size;
      logic [3:0]       strobe;
      logic [DataW-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic             addr_ok;
      logic             data_ok;
      logic [DataW-1:0] data;
   } dbus_resp_t;

   // A granted fetch becomes a word read on the downstream bus.
   function automatic dbus_req_t ibus_to_dbus(input logic [AddrW-1:0] addr);
      dbus_req_t r;
      r.valid  = 1'b1;
      r.addr   = addr;
      r.size   = SizeWord;
      r.strobe = 4'h0;
      r.data   = '0;
      return r;
   endfunction

endpackage

// File: rtl/mem_bus_arb_perf.sv
// Grant performance counters for mem_bus_arbiter; wrap modulo 2^CNT_W, cleared by reset only.
module mem_bus_arb_perf
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             igrant_inc_i,
   input  logic             dgrant_inc_i,
   output logic [CNT_W-1:0] perf_igrant_o,
   output logic [CNT_W-1:0] perf_dgrant_o
);

   logic [CNT_W-1:0] igrant_q, igrant_d;
   logic [CNT_W-1:0] dgrant_q, dgrant_d;

   // Count one per grant entry.
   always_comb begin
      igrant_d = igrant_q + CNT_W'(igrant_inc_i);
      dgrant_d = dgrant_q + CNT_W'(dgrant_inc_i);
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         igrant_q <= '0;
         dgrant_q <= '0;
      end else begin
         igrant_q <= igrant_d;
         dgrant_q <= dgrant_d;
      end
   end

   assign perf_igrant_o = igrant_q;
   assign perf_dgrant_o = dgrant_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the downstream bus between fetch (ibus) and memory stage (dbus).
// dbus has priority; after STARVE_MAX consecutive dbus grants with ibus pending, ibus wins.
// Optional grant counters are enabled by defining MEM_BUS_ARB_PERF_EN.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  ibus_req_t        ireq,
   output ibus_resp_t       iresp,
   input  dbus_req_t        dreq,
   output dbus_resp_t       dresp,
   output dbus_req_t        oreq,
   input  dbus_resp_t       oresp,
   output logic             grant_d,
   output logic [CNT_W-1:0] perf_igrant,
   output logic [CNT_W-1:0] perf_dgrant
);

   localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

   arb_state_t         state_q, state_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic               enter_i, enter_d;

   // Arbitrate only from IDLE; a grant is held until downstream data_ok.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (dreq.valid && (!ireq.valid || (starve_q < StarveMax))) begin
               state_d = ARB_GRANT_D;
            end else if (ireq.valid) begin
               state_d = ARB_GRANT_I;
            end
         end
         ARB_GRANT_I, ARB_GRANT_D: begin
            if (oresp.data_ok) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign enter_i = (state_q == ARB_IDLE) && (state_d == ARB_GRANT_I);
   assign enter_d = (state_q == ARB_IDLE) && (state_d == ARB_GRANT_D);

   // Starvation counter: counts dbus wins over a pending ibus, saturating.
   always_comb begin
      starve_d = starve_q;
      if (enter_i || ((state_q == ARB_IDLE) && !ireq.valid)) begin
         starve_d = '0;
      end else if (enter_d && (starve_q != StarveMax)) begin
         starve_d = starve_q + StarveW'(1);
      end
   end

   // State and starvation registers; reset drops any grant immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ARB_IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Output muxes depend only on registered state, never on request valid.
   always_comb begin
      oreq  = '0;
      iresp = '0;
      dresp = '0;
      case (state_q)
         ARB_GRANT_I: begin
            oreq          = ibus_to_dbus(ireq.addr);
            iresp.addr_ok = oresp.addr_ok;
            iresp.data_ok = oresp.data_ok;
            iresp.data    = oresp.data;
         end
         ARB_GRANT_D: begin
            oreq       = dreq;
            oreq.valid = 1'b1;
            dresp      = oresp;
         end
         default: ;
      endcase
   end

   assign grant_d = (state_q == ARB_GRANT_D);

`ifdef MEM_BUS_ARB_PERF_EN
   mem_bus_arb_perf #(
      .CNT_W(CNT_W)
   ) u_perf (
      .clk_i        (clk),
      .rst_ni       (reset_n),
      .igrant_inc_i (enter_i),
      .dgrant_inc_i (enter_d),
      .perf_igrant_o(perf_igrant),
      .perf_dgrant_o(perf_dgrant)
   );
`else
   assign perf_igrant = '0;
   assign perf_dgrant = '0;
`endif

   // Requesters must hold valid for the whole grant.
   a_ivalid_held : assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == ARB_GRANT_I) |-> ireq.valid)
      else $error("ibus valid dropped during grant");

   a_dvalid_held : assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == ARB_GRANT_D) |-> dreq.valid)
      else $error("dbus valid dropped during grant");

   // data_ok with no grant outstanding is ignored but indicates a downstream bug.
   a_no_idle_data_ok : assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == ARB_IDLE) |-> !oresp.data_ok)
      else $error("downstream data_ok while idle");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected grants, monitor checks them.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int unsigned CNT_W = 32;
   localparam logic [31:0] K     = 32'hA5A5_0F0F;
`ifdef MEM_BUS_ARB_PERF_EN
   localparam int unsigned ExpI = 3;
   localparam int unsigned ExpD = 2;
`else
   localparam int unsigned ExpI = 0;
   localparam int unsigned ExpD = 0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   ibus_req_t        ireq;
   ibus_resp_t       iresp;
   dbus_req_t        dreq;
   dbus_resp_t       dresp;
   dbus_req_t        oreq;
   dbus_resp_t       oresp;
   logic             grant_d;
   logic [CNT_W-1:0] perf_igrant;
   logic [CNT_W-1:0] perf_dgrant;

   int nvec = 0;
   int nerr = 0;
   int lat  = 3;

   typedef struct packed {
      logic        is_d;
      logic [31:0] addr;
      logic [31:0] rdata;
   } exp_t;
   exp_t expq[$];

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .STARVE_MAX(4),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ireq       (ireq),
      .iresp      (iresp),
      .dreq       (dreq),
      .dresp      (dresp),
      .oreq       (oreq),
      .oresp      (oresp),
      .grant_d    (grant_d),
      .perf_igrant(perf_igrant),
      .perf_dgrant(perf_dgrant)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void exp_push(input logic is_d, input logic [31:0] addr);
      exp_t e;
      e.is_d  = is_d;
      e.addr  = addr;
      e.rdata = addr ^ K;
      expq.push_back(e);
   endfunction

   // Downstream model: addr_ok on first grant cycle, data_ok on cycle lat-1.
   initial begin : responder
      int cnt;
      bit busy;
      busy  = 0;
      cnt   = 0;
      oresp = '0;
      forever begin
         @(posedge clk);
         #1;
         if (oreq.valid) begin
            if (!busy) begin
               busy = 1;
               cnt  = 0;
            end else begin
               cnt++;
            end
            oresp.addr_ok = (cnt == 0);
            oresp.data_ok = (cnt == lat - 1);
            oresp.data    = (cnt == lat - 1) ? (oreq.addr ^ K) : 32'h0;
         end else begin
            busy  = 0;
            oresp = '0;
         end
      end
   end

   // Monitor: pops an expectation on every new grant and checks the response path.
   initial begin : monitor
      exp_t cur;
      logic have_cur, prev_valid, prev_dok;
      have_cur   = 0;
      prev_valid = 0;
      prev_dok   = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            have_cur   = 0;
            prev_valid = 0;
            prev_dok   = 0;
         end else begin
            if (prev_dok) chk("release_idle", 64'(oreq.valid), 64'd0);
            if (!oreq.valid) chk("idle_resp_zero", 64'({iresp, dresp}), 64'd0);
            if (oreq.valid && !prev_valid) begin
               if (expq.size() == 0) begin
                  nvec++;
                  nerr++;
                  have_cur = 0;
                  $display("FAIL unexpected_grant: addr 0x%0h grant_d %0b, none expected",
                           oreq.addr, grant_d);
               end else begin
                  cur      = expq.pop_front();
                  have_cur = 1;
                  chk("grant_owner", 64'(grant_d), 64'(cur.is_d));
                  chk("grant_addr", 64'(oreq.addr), 64'(cur.addr));
               end
            end
            if (oreq.valid && have_cur) begin
               if (cur.is_d) begin
                  chk("iresp_quiet", 64'(iresp), 64'd0);
                  chk("dresp_addr_ok", 64'(dresp.addr_ok), 64'(oresp.addr_ok));
               end else begin
                  chk("dresp_quiet", 64'(dresp), 64'd0);
                  chk("iresp_addr_ok", 64'(iresp.addr_ok), 64'(oresp.addr_ok));
               end
               if (oresp.data_ok) begin
                  chk("resp_data_ok", 64'(cur.is_d ? dresp.data_ok : iresp.data_ok), 64'd1);
                  chk("resp_data", 64'(cur.is_d ? dresp.data : iresp.data), 64'(cur.rdata));
                  have_cur = 0;
               end
            end
            prev_valid = oreq.valid;
            prev_dok   = oreq.valid && oresp.data_ok;
         end
      end
   end

   task automatic wait_d();
      bit got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (dresp.data_ok) got = 1;
      end
      if (!got) begin
         nvec++;
         nerr++;
         $display("FAIL d_timeout: dresp.data_ok 0 after 200 cycles, required 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_i();
      bit got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (iresp.data_ok) got = 1;
      end
      if (!got) begin
         nvec++;
         nerr++;
         $display("FAIL i_timeout: iresp.data_ok 0 after 200 cycles, required 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [31:0] addr);
      dreq.valid  = 1'b1;
      dreq.addr   = addr;
      dreq.size   = SizeWord;
      dreq.strobe = 4'hF;
      dreq.data   = ~addr;
   endtask

   task automatic set_i(input logic [31:0] addr);
      ireq.valid = 1'b1;
      ireq.addr  = addr;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset_n = 1'b0;
      ireq    = '0;
      dreq    = '0;
      lat     = 3;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_oreq_valid", 64'(oreq.valid), 64'd0);
      chk("rst_grant_d", 64'(grant_d), 64'd0);
      chk("rst_iresp_ok", 64'({iresp.addr_ok, iresp.data_ok}), 64'd0);
      chk("rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
      chk("rst_perf_i", 64'(perf_igrant), 64'd0);
      chk("rst_perf_d", 64'(perf_dgrant), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // dbus only, three-cycle transfer.
      lat = 3;
      exp_push(1'b1, 32'h8000_0010);
      set_d(32'h8000_0010);
      @(negedge clk);
      chk("arb_cycle_no_oreq", 64'(oreq.valid), 64'd0);
      wait_d();
      dreq.valid = 1'b0;
      @(posedge clk);
      #1;

      // Both requesters valid out of reset: dbus first, then ibus after one idle cycle.
      reset_n = 1'b0;
      exp_push(1'b1, 32'h8000_0020);
      exp_push(1'b0, 32'h0000_0040);
      set_d(32'h8000_0020);
      set_i(32'h0000_0040);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      fork
         begin
            wait_d();
            dreq.valid = 1'b0;
         end
         begin
            wait_i();
            ireq.valid = 1'b0;
         end
      join
      @(posedge clk);
      #1;

      // Starvation cap: ibus held against five back-to-back dbus requests.
      lat = 2;
      for (int k = 0; k < 4; k++) exp_push(1'b1, 32'h8000_0100 + 32'(4 * k));
      exp_push(1'b0, 32'h0000_1000);
      exp_push(1'b1, 32'h8000_0110);
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               set_d(32'h8000_0100 + 32'(4 * k));
               wait_d();
            end
            dreq.valid = 1'b0;
         end
         begin
            set_i(32'h0000_1000);
            wait_i();
            ireq.valid = 1'b0;
         end
      join
      @(posedge clk);
      #1;

      // addr_ok and data_ok together in the first grant cycle.
      lat = 1;
      exp_push(1'b1, 32'h8000_0200);
      set_d(32'h8000_0200);
      wait_d();
      dreq.valid = 1'b0;
      @(posedge clk);
      #1;

      // Reset while ibus holds the bus with addr_ok asserted.
      lat = 100;
      exp_push(1'b0, 32'h0000_2000);
      set_i(32'h0000_2000);
      @(negedge clk);
      @(negedge clk);
      chk("t4_granted", 64'(oreq.valid), 64'd1);
      chk("t4_addr_ok", 64'(iresp.addr_ok), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t4_oreq_dropped", 64'(oreq.valid), 64'd0);
      chk("t4_iresp_addr_ok", 64'(iresp.addr_ok), 64'd0);
      chk("t4_grant_d", 64'(grant_d), 64'd0);
      chk("t4_state_idle", 64'(dut.state_q), 64'(ARB_IDLE));
      chk("t4_starve_zero", 64'(dut.starve_q), 64'd0);
      ireq.valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Grant counters: three ibus and two dbus grants since reset.
      lat = 2;
      for (int k = 0; k < 3; k++) begin
         exp_push(1'b0, 32'h0000_3000 + 32'(4 * k));
         set_i(32'h0000_3000 + 32'(4 * k));
         wait_i();
         ireq.valid = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         exp_push(1'b1, 32'h8000_3000 + 32'(4 * k));
         set_d(32'h8000_3000 + 32'(4 * k));
         wait_d();
         dreq.valid = 1'b0;
      end
      @(negedge clk);
      chk("perf_igrant", 64'(perf_igrant), 64'(ExpI));
      chk("perf_dgrant", 64'(perf_dgrant), 64'(ExpD));
      chk("queue_drain", 64'(expq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
